banked_mem: RTL

BANKED_MEM -- requirements
Module: banked_mem

---
 rtl/banked_mem.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/banked_mem.sv
// ---------------------------------------------------------------------------
// banked_mem
//
// Multi-bank memory with lane-granular writes and full-row reads.
// Each of the NUM_BANKS banks holds 2^BANK_ADDR_W rows of DATA_W bits.
// A write targets one lane (one bank, one row). A read returns the same row
// from every bank at once, packed into rd_data with a zero pad bit under
// each lane. After reset, or after a clear request, the block zero-fills
// every row of every bank, one row per cycle, before it accepts traffic.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   wr_en      - write strobe for one lane
//   wr_addr    - {bank index, row}; the low BANK_ADDR_W bits are the row
//   wr_data    - write data for the selected lane
//   rd_en      - read request for one full row across all banks
//   rd_addr    - row to read
//   clear_req  - single-cycle pulse that restarts the zero-fill
//   rd_data    - lane k at [k*(DATA_W+1)+1 +: DATA_W], bit k*(DATA_W+1) = 0
//   rd_valid   - single-cycle pulse marking new rd_data
//   init_busy  - high while the zero-fill runs
//
// Build option:
//   BANKED_MEM_OUTREG_EN - adds an output register stage; read latency
//                          becomes 2 cycles and rd_valid follows it.
// ---------------------------------------------------------------------------
module banked_mem #(
    parameter int DATA_W      = 8,
    parameter int BANK_ADDR_W = 10,
    parameter int NUM_BANKS   = 2,
    localparam int SEL_W      = $clog2(NUM_BANKS),
    localparam int LANE_W     = DATA_W + 1,
    localparam int RD_W       = NUM_BANKS * LANE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [BANK_ADDR_W+SEL_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    input  logic [BANK_ADDR_W-1:0]       rd_addr,
    input  logic                         clear_req,
    output logic [RD_W-1:0]              rd_data,
    output logic                         rd_valid,
    output logic                         init_busy
);

    localparam int ROWS = 1 << BANK_ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [BANK_ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0]      mem [NUM_BANKS][ROWS];

    logic [SEL_W-1:0]       wr_bank;
    logic [BANK_ADDR_W-1:0] wr_row;
    logic                   rd_fire;
    logic [RD_W-1:0]        rd_row;

    logic                   rd_valid_s1;
    logic [RD_W-1:0]        rd_data_s1;

    assign wr_bank   = wr_addr[BANK_ADDR_W +: SEL_W];
    assign wr_row    = wr_addr[BANK_ADDR_W-1:0];
    assign rd_fire   = (state_q == RUN) && rd_en;
    assign init_busy = (state_q == INIT);

    // State and fill-counter register. Reset drops straight back into INIT
    // with the counter at row 0, so a reset at any point restarts the fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. INIT walks the counter across every row and hands
    // over to RUN on the cycle after the last row is zeroed. In RUN a clear
    // request re-enters INIT; a write or read in that same cycle still
    // completes because the memory and read pipeline look at state_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BANK_ADDR_W'(ROWS - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Memory array. Contents are deliberately not reset; the fill is what
    // clears them. During INIT every bank zeroes the counter row together,
    // and user writes are ignored. In RUN only the addressed lane changes.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem[b][cnt_q] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_bank][wr_row] <= wr_data;
        end
    end

    // Gather one row from every bank into the padded output layout. The
    // zero default leaves every pad bit at 0.
    always_comb begin
        rd_row = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            rd_row[k*LANE_W+1 +: DATA_W] = mem[k][rd_addr];
        end
    end

    // First read stage. The array is sampled on the same edge that commits
    // any write, so a same-row read and write returns the old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_s1 <= 1'b0;
            rd_data_s1  <= '0;
        end else begin
            rd_valid_s1 <= rd_fire;
            if (rd_fire) begin
                rd_data_s1 <= rd_row;
            end
        end
    end

`ifdef BANKED_MEM_OUTREG_EN
    logic            rd_valid_s2;
    logic [RD_W-1:0] rd_data_s2;

    // Optional output stage. It is never flushed by a clear request, so a
    // read issued just before a clear still emerges one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_s2 <= 1'b0;
            rd_data_s2  <= '0;
        end else begin
            rd_valid_s2 <= rd_valid_s1;
            if (rd_valid_s1) begin
                rd_data_s2 <= rd_data_s1;
            end
        end
    end

    assign rd_valid = rd_valid_s2;
    assign rd_data  = rd_data_s2;
`else
    assign rd_valid = rd_valid_s1;
    assign rd_data  = rd_data_s1;
`endif

endmodule
